// File: rtl/ddr2_ui_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_ui_pkg
// Description : Shared DDR2 user-interface command definitions: command codes
//               and the position of the command field in the address word.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr2_ui_pkg;

    typedef logic [2:0] cmd_code_t;

    localparam cmd_code_t CMD_WRITE = 3'b100;
    localparam cmd_code_t CMD_READ  = 3'b101;

    // The command field occupies [ADDR_W-CMD_MSB_OFS : ADDR_W-CMD_LSB_OFS]
    localparam int CMD_MSB_OFS = 2;
    localparam int CMD_LSB_OFS = 4;

    function automatic logic is_write_cmd(input cmd_code_t code);
        return (code == CMD_WRITE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr2_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_sync_fifo
// Description : Single-clock first-word-fall-through FIFO with occupancy
//               count and registered almost-full flag. Head reads 0 when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr2_sync_fifo #(
    parameter int WIDTH        = 36,
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_almost_full
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_almost_full;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_push & ~w_full;
    assign w_pop   = i_pop & ~w_empty;

    // Storage array; contents need no reset because the head is masked when empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, occupancy and almost-full flag (flag lags the count by one cycle)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_almost_full <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            r_almost_full <= (r_count >= c_CNT_W'(DEPTH - AFULL_MARGIN));
        end
    end

    assign o_head        = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count       = r_count;
    assign o_full        = w_full;
    assign o_almost_full = r_almost_full;

endmodule
`default_nettype wire

// File: rtl/ddr2_app_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_app_fifo_ctrl
// Description : Application-side command and write-data buffer for the DDR2
//               controller. Write commands are held back until their whole
//               burst of data is buffered; overflow/underflow are sticky.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr2_app_fifo_ctrl
    import ddr2_ui_pkg::*;
#(
    parameter int ADDR_W           = 36,
    parameter int DATA_W           = 128,
    parameter int MASK_W           = 16,
    parameter int AF_DEPTH         = 16,
    parameter int WDF_DEPTH        = 64,
    parameter int BURST_WORDS      = 2,
    parameter int AF_AFULL_MARGIN  = 4,
    parameter int WDF_AFULL_MARGIN = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           init_done,
    input  logic [ADDR_W-1:0]              app_af_addr,
    input  logic                           app_af_wren,
    input  logic [DATA_W-1:0]              app_wdf_data,
    input  logic [MASK_W-1:0]              app_mask_data,
    input  logic                           app_wdf_wren,
    input  logic                           ctrl_af_rden,
    input  logic                           ctrl_wdf_rden,
    output logic [ADDR_W-1:0]              af_addr,
    output logic                           af_empty,
    output logic                           af_almost_full,
    output logic [DATA_W-1:0]              wdf_data,
    output logic [MASK_W-1:0]              mask_data,
    output logic                           wdf_almost_full,
    output logic [$clog2(AF_DEPTH+1)-1:0]  af_count,
    output logic [$clog2(WDF_DEPTH+1)-1:0] wdf_count,
    output logic                           overflow_err,
    output logic                           underflow_err
);

    localparam int c_WDF_CNT_W = $clog2(WDF_DEPTH + 1);

    logic                     w_af_full;
    logic                     w_wdf_full;
    logic                     w_af_push;
    logic                     w_wdf_push;
    logic                     w_af_pop;
    logic                     w_wdf_pop;
    logic                     w_af_ovf;
    logic                     w_wdf_ovf;
    logic                     w_af_unf;
    logic                     w_wdf_unf;
    cmd_code_t                w_head_code;
    logic                     w_head_is_write;
    logic [c_WDF_CNT_W:0]     w_need;
    logic                     w_eligible;
    logic                     w_af_pop_write;
    logic [c_WDF_CNT_W-1:0]   w_pending_add;
    logic [c_WDF_CNT_W-1:0]   w_pending_sub;
    logic [c_WDF_CNT_W-1:0]   r_pending;
    logic                     r_overflow;
    logic                     r_underflow;

    // Application pushes: only while initialised; a push into a full FIFO is an error
    assign w_af_push  = app_af_wren  & init_done & ~w_af_full;
    assign w_wdf_push = app_wdf_wren & init_done & ~w_wdf_full;
    assign w_af_ovf   = app_af_wren  & init_done &  w_af_full;
    assign w_wdf_ovf  = app_wdf_wren & init_done &  w_wdf_full;

    // A write command is released only once its burst is buffered beyond the
    // data already owed to earlier released writes
    assign w_head_code     = af_addr[ADDR_W-CMD_MSB_OFS : ADDR_W-CMD_LSB_OFS];
    assign w_head_is_write = is_write_cmd(w_head_code);
    assign w_need          = {1'b0, r_pending} + (c_WDF_CNT_W + 1)'(BURST_WORDS);
    assign w_eligible      = (af_count != '0) &&
                             (!w_head_is_write || ({1'b0, wdf_count} >= w_need));
    assign af_empty        = ~w_eligible;

    // Controller pops: ignored (and flagged) when nothing is available
    assign w_af_pop       = ctrl_af_rden & w_eligible;
    assign w_af_unf       = ctrl_af_rden & ~w_eligible;
    assign w_wdf_pop      = ctrl_wdf_rden & (wdf_count != '0);
    assign w_wdf_unf      = ctrl_wdf_rden & (wdf_count == '0);
    assign w_af_pop_write = w_af_pop & w_head_is_write;

    assign w_pending_add = w_af_pop_write ? c_WDF_CNT_W'(BURST_WORDS) : '0;
    assign w_pending_sub = (w_wdf_pop && (r_pending != '0)) ? c_WDF_CNT_W'(1) : '0;

    // Credit owed to released write commands; release and data pop may coincide
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= r_pending + w_pending_add - w_pending_sub;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_af_ovf || w_wdf_ovf) begin
                r_overflow <= 1'b1;
            end
            if (w_af_unf || w_wdf_unf) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow_err  = r_overflow;
    assign underflow_err = r_underflow;

    ddr2_sync_fifo #(
        .WIDTH        (ADDR_W),
        .DEPTH        (AF_DEPTH),
        .AFULL_MARGIN (AF_AFULL_MARGIN)
    ) u_af_fifo (
        .clk           (clk),
        .reset         (reset),
        .i_push        (w_af_push),
        .i_push_data   (app_af_addr),
        .i_pop         (w_af_pop),
        .o_head        (af_addr),
        .o_count       (af_count),
        .o_full        (w_af_full),
        .o_almost_full (af_almost_full)
    );

    ddr2_sync_fifo #(
        .WIDTH        (MASK_W + DATA_W),
        .DEPTH        (WDF_DEPTH),
        .AFULL_MARGIN (WDF_AFULL_MARGIN)
    ) u_wdf_fifo (
        .clk           (clk),
        .reset         (reset),
        .i_push        (w_wdf_push),
        .i_push_data   ({app_mask_data, app_wdf_data}),
        .i_pop         (w_wdf_pop),
        .o_head        ({mask_data, wdf_data}),
        .o_count       (wdf_count),
        .o_full        (w_wdf_full),
        .o_almost_full (wdf_almost_full)
    );

endmodule
`default_nettype wire
